// File: rtl/usb3_tx_hdr_sched_if.sv
// usb3_tx_hdr_sched_if: requester and link header-transmit signals of the header scheduler.
// master is the scheduler side; slave is the requesters/link side.
interface usb3_tx_hdr_sched_if #(
    parameter int N     = 4,
    parameter int HDR_W = 36
);
    logic               link_up;
    logic [N-1:0]       req;
    logic [N*HDR_W-1:0] req_hdr;
    logic [N-1:0]       grant;
    logic [N-1:0]       req_ack;
    logic [N-1:0]       req_err;
    logic               tx_tp;
    logic [HDR_W-1:0]   tx_hdr;
    logic               tx_ack;
    logic               busy;

    modport master (
        input  link_up, req, req_hdr, tx_ack,
        output grant, req_ack, req_err, tx_tp, tx_hdr, busy
    );

    modport slave (
        output link_up, req, req_hdr, tx_ack,
        input  grant, req_ack, req_err, tx_tp, tx_hdr, busy
    );
endinterface

// File: rtl/usb3_tx_hdr_sched.sv
// usb3_tx_hdr_sched: round-robin arbiter for the link transmit-header path.
// Holds a granted header until tx_ack, re-presents it on timeout, drops it after MAX_RETRY retries.
module usb3_tx_hdr_sched #(
    parameter int N         = 4,
    parameter int HDR_W     = 36,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input logic                 clk,
    input logic                 reset,
    usb3_tx_hdr_sched_if.master bus
);
    localparam int PW = $clog2(N);
    localparam int WW = $clog2(TIMEOUT);
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, WAIT, RETRY} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n, k, k_n, sel, j;
    logic             found;
    logic [WW-1:0]    wcnt, wcnt_n;
    logic [RW-1:0]    rcnt, rcnt_n;
    logic [N-1:0]     grant_n, ack_n, err_n;
    logic             tp_n;
    logic [HDR_W-1:0] hdr_n;

    // circular search starting just after the last completed owner
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        j     = ptr;
        for (int i = 1; i <= N; i++) begin
            j = PW'((int'(ptr) + i) % N);
            if (!found && bus.req[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        k_n     = k;
        wcnt_n  = wcnt;
        rcnt_n  = rcnt;
        grant_n = bus.grant;
        hdr_n   = bus.tx_hdr;
        tp_n    = bus.tx_tp;
        ack_n   = '0;
        err_n   = '0;
        case (state)
            IDLE: if (bus.link_up && found) begin
                state_n = WAIT;
                k_n     = sel;
                grant_n = N'(1) << sel;
                hdr_n   = bus.req_hdr[sel*HDR_W +: HDR_W];
                tp_n    = 1'b1;
                wcnt_n  = '0;
                rcnt_n  = '0;
            end
            WAIT: if (bus.tx_ack) begin
                state_n = IDLE;
                ack_n   = bus.grant;
                ptr_n   = k;
                grant_n = '0;
                tp_n    = 1'b0;
            end else if (!bus.link_up) begin
                state_n = IDLE;
                grant_n = '0;
                tp_n    = 1'b0;
            end else if (wcnt == W_LAST) begin
                tp_n = 1'b0;
                if (rcnt < R_MAX) begin
                    state_n = RETRY;
                    rcnt_n  = rcnt + RW'(1);
                end else begin
                    state_n = IDLE;
                    err_n   = bus.grant;
                    ptr_n   = k;
                    grant_n = '0;
                end
            end else begin
                wcnt_n = wcnt + WW'(1);
            end
            RETRY: if (!bus.link_up) begin
                state_n = IDLE;
                grant_n = '0;
            end else begin
                state_n = WAIT;
                tp_n    = 1'b1;
                wcnt_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= PW'(N - 1);
            k           <= '0;
            wcnt        <= '0;
            rcnt        <= '0;
            bus.grant   <= '0;
            bus.tx_hdr  <= '0;
            bus.tx_tp   <= 1'b0;
            bus.req_ack <= '0;
            bus.req_err <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            k           <= k_n;
            wcnt        <= wcnt_n;
            rcnt        <= rcnt_n;
            bus.grant   <= grant_n;
            bus.tx_hdr  <= hdr_n;
            bus.tx_tp   <= tp_n;
            bus.req_ack <= ack_n;
            bus.req_err <= err_n;
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_usb3_tx_hdr_sched.sv
// tb_usb3_tx_hdr_sched: scenario tasks with a completion scoreboard for usb3_tx_hdr_sched.
module tb_usb3_tx_hdr_sched;
    localparam int N = 4, HDR_W = 36, TIMEOUT = 4, MAX_RETRY = 3;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [N-1:0] err;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    logic [HDR_W-1:0] hdr [N];

    always #5 clk = ~clk;

    usb3_tx_hdr_sched_if #(.N(N), .HDR_W(HDR_W)) bus();

    usb3_tx_hdr_sched #(.N(N), .HDR_W(HDR_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // every completion pulse seen on the DUT, in order
    always @(negedge clk)
        if (bus.req_ack != '0 || bus.req_err != '0) obs_q.push_back(ev_t'{bus.req_ack, bus.req_err});

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic drain(input string name);
        tick(2);
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL %s_sb missing got=none exp ack=%b err=%b", name, e.ack, e.err);
            end else begin
                ev_t o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL %s_sb got ack=%b err=%b exp ack=%b err=%b", name, o.ack, o.err, e.ack, e.err);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL %s_sb_extra got=%0d extra events exp=0", name, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        total++;
        if ({bus.grant, bus.req_ack, bus.req_err, bus.tx_tp, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0", {bus.grant, bus.req_ack, bus.req_err, bus.tx_tp, bus.busy});
        end
        total++;
        if (bus.tx_hdr !== '0) begin bad++; $display("FAIL reset_hdr got=%h exp=0", bus.tx_hdr); end
        reset = 1'b0;
        tick(2);
        total++;
        if ({bus.grant, bus.tx_tp, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=0", {bus.grant, bus.tx_tp, bus.busy});
        end
    endtask

    task automatic test_single();
        bus.req = 4'b0001;
        tick(1);
        total++;
        if (bus.tx_tp !== 1'b1) begin bad++; $display("FAIL single_tp got=%b exp=1", bus.tx_tp); end
        total++;
        if (bus.grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.grant); end
        total++;
        if (bus.tx_hdr !== 36'h123456789) begin bad++; $display("FAIL single_hdr got=%h exp=123456789", bus.tx_hdr); end
        exp_q.push_back(ev_t'{4'b0001, 4'b0000});
        tick(2);
        total++;
        if ({bus.tx_tp, bus.busy, bus.tx_hdr} !== {2'b11, 36'h123456789}) begin
            bad++;
            $display("FAIL single_hold got=%b/%h exp=11/123456789", {bus.tx_tp, bus.busy}, bus.tx_hdr);
        end
        bus.tx_ack = 1'b1;
        tick(1);
        bus.tx_ack = 1'b0;
        bus.req = '0;
        total++;
        if ({bus.req_ack, bus.tx_tp, bus.grant} !== {4'b0001, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL single_ack got=%b exp=000100000", {bus.req_ack, bus.tx_tp, bus.grant});
        end
        tick(1);
        total++;
        if (bus.req_ack !== '0) begin bad++; $display("FAIL single_ack_pulse got=%b exp=0000", bus.req_ack); end
        drain("single");
    endtask

    task automatic test_round_robin();
        int last = 0;
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            logic [N-1:0] oh = 4'b0001 << (i % N);
            while (!bus.tx_tp && n < 10) begin tick(1); n++; end
            total++;
            if (bus.tx_tp !== 1'b1) begin bad++; $display("FAIL rr_wait_%0d got=%b exp=1", i, bus.tx_tp); end
            total++;
            if (bus.grant !== oh) begin bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, bus.grant, oh); end
            total++;
            if (bus.tx_hdr !== hdr[i%N]) begin bad++; $display("FAIL rr_hdr_%0d got=%h exp=%h", i, bus.tx_hdr, hdr[i%N]); end
            if (i > 0) begin
                total++;
                if (cyc - last != 3) begin bad++; $display("FAIL rr_gap_%0d got=%0d exp=3", i, cyc - last); end
            end
            last = cyc;
            exp_q.push_back(ev_t'{oh, 4'b0000});
            tick(1);
            bus.tx_ack = 1'b1;
            tick(1);
            bus.tx_ack = 1'b0;
            if (i == 4) bus.req = '0;
            total++;
            if (bus.req_ack !== oh) begin bad++; $display("FAIL rr_ack_%0d got=%b exp=%b", i, bus.req_ack, oh); end
        end
        drain("rr");
    endtask

    task automatic test_timeout();
        bus.req = 4'b0100;
        tick(1);
        total++;
        if (bus.grant !== 4'b0100) begin bad++; $display("FAIL to_grant got=%b exp=0100", bus.grant); end
        exp_q.push_back(ev_t'{4'b0000, 4'b0100});
        for (int c = 0; c < 19; c++) begin
            logic e = (c % 5) != 4;
            total++;
            if (bus.tx_tp !== e) begin bad++; $display("FAIL to_tp_c%0d got=%b exp=%b", c, bus.tx_tp, e); end
            tick(1);
        end
        bus.req = '0;
        total++;
        if ({bus.req_err, bus.req_ack, bus.tx_tp, bus.grant} !== {4'b0100, 4'b0000, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL to_err got=%b exp=0100000000000", {bus.req_err, bus.req_ack, bus.tx_tp, bus.grant});
        end
        drain("timeout");
    endtask

    task automatic test_late_ack();
        bus.req = 4'b1011;
        tick(1);
        total++;
        if (bus.grant !== 4'b1000) begin bad++; $display("FAIL late_grant got=%b exp=1000", bus.grant); end
        total++;
        if (bus.tx_hdr !== hdr[3]) begin bad++; $display("FAIL late_hdr got=%h exp=%h", bus.tx_hdr, hdr[3]); end
        exp_q.push_back(ev_t'{4'b1000, 4'b0000});
        tick(4);
        total++;
        if ({bus.tx_tp, bus.busy} !== 2'b01) begin bad++; $display("FAIL late_retry_gap got=%b exp=01", {bus.tx_tp, bus.busy}); end
        tick(7);
        total++;
        if (bus.tx_tp !== 1'b1) begin bad++; $display("FAIL late_third_tp got=%b exp=1", bus.tx_tp); end
        bus.tx_ack = 1'b1;
        tick(1);
        bus.tx_ack = 1'b0;
        bus.req = 4'b0011;
        total++;
        if ({bus.req_ack, bus.req_err, bus.tx_tp} !== {4'b1000, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL late_ack got=%b exp=100000000", {bus.req_ack, bus.req_err, bus.tx_tp});
        end
        tick(1);
        total++;
        if (bus.grant !== 4'b0001) begin bad++; $display("FAIL late_next_grant got=%b exp=0001", bus.grant); end
        exp_q.push_back(ev_t'{4'b0001, 4'b0000});
        bus.tx_ack = 1'b1;
        tick(1);
        bus.tx_ack = 1'b0;
        bus.req = '0;
        drain("late");
    endtask

    task automatic test_link_loss();
        bus.req = 4'b0110;
        tick(1);
        total++;
        if (bus.grant !== 4'b0010) begin bad++; $display("FAIL link_grant got=%b exp=0010", bus.grant); end
        bus.link_up = 1'b0;
        tick(1);
        total++;
        if ({bus.tx_tp, bus.grant, bus.busy} !== '0) begin
            bad++;
            $display("FAIL link_abort got=%b exp=0", {bus.tx_tp, bus.grant, bus.busy});
        end
        tick(2);
        total++;
        if (bus.tx_tp !== 1'b0) begin bad++; $display("FAIL link_gated got=%b exp=0", bus.tx_tp); end
        bus.link_up = 1'b1;
        tick(1);
        total++;
        if (bus.grant !== 4'b0010) begin bad++; $display("FAIL link_regrant got=%b exp=0010", bus.grant); end
        total++;
        if (bus.tx_hdr !== hdr[1]) begin bad++; $display("FAIL link_rehdr got=%h exp=%h", bus.tx_hdr, hdr[1]); end
        exp_q.push_back(ev_t'{4'b0010, 4'b0000});
        bus.tx_ack = 1'b1;
        tick(1);
        bus.tx_ack = 1'b0;
        bus.req = 4'b0100;
        tick(1);
        total++;
        if (bus.grant !== 4'b0100) begin bad++; $display("FAIL link_next got=%b exp=0100", bus.grant); end
        exp_q.push_back(ev_t'{4'b0100, 4'b0000});
        bus.tx_ack = 1'b1;
        tick(1);
        bus.tx_ack = 1'b0;
        bus.req = '0;
        drain("link");
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b1111;
        tick(1);
        total++;
        if (bus.tx_tp !== 1'b1) begin bad++; $display("FAIL rmid_tp got=%b exp=1", bus.tx_tp); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.tx_tp, bus.grant, bus.busy, bus.tx_hdr} !== '0) begin
            bad++;
            $display("FAIL rmid_async got=%b/%h exp=0", {bus.tx_tp, bus.grant, bus.busy}, bus.tx_hdr);
        end
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        tick(1);
        total++;
        if (bus.grant !== 4'b0001) begin bad++; $display("FAIL rmid_first got=%b exp=0001", bus.grant); end
        exp_q.push_back(ev_t'{4'b0001, 4'b0000});
        bus.tx_ack = 1'b1;
        tick(1);
        bus.tx_ack = 1'b0;
        bus.req = '0;
        drain("rmid");
    endtask

    initial begin
        hdr[0] = 36'h123456789;
        hdr[1] = 36'hA5A5A5A51;
        hdr[2] = 36'h0FEDCBA98;
        hdr[3] = 36'h800000003;
        bus.link_up = 1'b1;
        bus.req = '0;
        bus.tx_ack = 1'b0;
        for (int i = 0; i < N; i++) bus.req_hdr[i*HDR_W +: HDR_W] = hdr[i];
        tick(2);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_late_ack();
        test_link_loss();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
